// File: rtl/tv80_reg_banked.sv
// tv80_reg_banked: banked H/L register-pair store for the TV80 core.
// EXX and EX DE,HL are done by flipping mapping flops, never by moving data.
// Optional debug port: define TV80_REG_DEBUG_EN to expose the flattened
// physical contents on dbg_regs.
module tv80_reg_banked #(
  parameter int DW     = 8,
  parameter int BANKED = 3,
  parameter int INDEX  = 2,
  parameter int AW     = 3,
  parameter int SWAP_A = 1,
  parameter int SWAP_B = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cen,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [AW-1:0] addr_c,
  input  logic          weh,
  input  logic          wel,
  input  logic [DW-1:0] dih,
  input  logic [DW-1:0] dil,
  input  logic          exx,
  input  logic          ex_de_hl,
  output logic [DW-1:0] doah,
  output logic [DW-1:0] doal,
  output logic [DW-1:0] dobh,
  output logic [DW-1:0] dobl,
  output logic [DW-1:0] doch,
  output logic [DW-1:0] docl,
  output logic          bank_sel,
  output logic [1:0]    swap_flags
`ifdef TV80_REG_DEBUG_EN
  , output logic [(2*BANKED+INDEX)*2*DW-1:0] dbg_regs
`endif
);

  localparam int NP = 2*BANKED + INDEX;   // physical pairs
  localparam int PW = $clog2(NP + 1);     // physical index width; NP means "no pair"

  logic [NP-1:0][DW-1:0] r_h, r_l;
  logic                  r_bank;
  logic [1:0]            r_swap;

  logic [2:0][AW-1:0]    w_addr;
  logic [2:0][PW-1:0]    w_pa;
  logic [2:0][DW-1:0]    w_rh, w_rl;
  logic                  w_swp;

  // Logical pair -> physical pair; out-of-range addresses map to NP (no pair).
  function automatic logic [PW-1:0] phys_of(input logic [AW-1:0] a,
                                            input logic bsel, input logic swp);
    int l;
    int r;
    l = int'(a);
    if (l < BANKED) begin
      if (swp && l == SWAP_A)      l = SWAP_B;
      else if (swp && l == SWAP_B) l = SWAP_A;
      r = (bsel ? BANKED : 0) + l;
    end else if (l < BANKED + INDEX) begin
      r = BANKED + l;                     // index pairs sit after both banks
    end else begin
      r = NP;
    end
    return PW'(r);
  endfunction

  assign w_swp  = r_swap[r_bank];
  assign w_addr = {addr_c, addr_b, addr_a};

  // Port 0 is both read port A and the write address.
  for (genvar k = 0; k < 3; k++) begin : g_rd
    assign w_pa[k] = phys_of(w_addr[k], r_bank, w_swp);

    // Combinational read mux; unmapped addresses read zero.
    always_comb begin
      w_rh[k] = '0;
      w_rl[k] = '0;
      for (int p = 0; p < NP; p++) begin
        if (w_pa[k] == PW'(p)) begin
          w_rh[k] = r_h[p];
          w_rl[k] = r_l[p];
        end
      end
    end
  end

  assign doah = w_rh[0];
  assign doal = w_rl[0];
  assign dobh = w_rh[1];
  assign dobl = w_rl[1];
  assign doch = w_rh[2];
  assign docl = w_rl[2];
  assign bank_sel   = r_bank;
  assign swap_flags = r_swap;

  // Storage and mapping state; the write uses the pre-update map, so a swap
  // in the same cycle only affects later cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_h    <= '0;
      r_l    <= '0;
      r_bank <= 1'b0;
      r_swap <= 2'b00;
    end else if (cen) begin
      if (exx)      r_bank         <= ~r_bank;
      if (ex_de_hl) r_swap[r_bank] <= ~r_swap[r_bank];
      for (int p = 0; p < NP; p++) begin
        if (w_pa[0] == PW'(p)) begin
          if (weh) r_h[p] <= dih;
          if (wel) r_l[p] <= dil;
        end
      end
    end
  end

`ifdef TV80_REG_DEBUG_EN
  // Unmapped physical view: pair p = {H,L} at [p*2*DW +: 2*DW].
  always_comb begin
    dbg_regs = '0;
    for (int p = 0; p < NP; p++) dbg_regs[p*2*DW +: 2*DW] = {r_h[p], r_l[p]};
  end
`endif

endmodule

// File: tb/tb_tv80_reg_banked.sv
// Scoreboard bench for tv80_reg_banked: stimulus pushes expected read-port
// values and mapping state; a negedge monitor pops and compares.
module tb_tv80_reg_banked;

  logic       clk = 1'b0;
  logic       reset_n, cen, weh, wel, exx, ex_de_hl;
  logic [2:0] addr_a, addr_b, addr_c;
  logic [7:0] dih, dil;
  logic [7:0] doah, doal, dobh, dobl, doch, docl;
  logic       bank_sel;
  logic [1:0] swap_flags;

  typedef struct {
    string       name;
    logic [15:0] ea, eb, ec;
    logic        ebank;
    logic [1:0]  esw;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;

  tv80_reg_banked dut (
    .clk(clk), .reset_n(reset_n), .cen(cen),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .weh(weh), .wel(wel), .dih(dih), .dil(dil),
    .exx(exx), .ex_de_hl(ex_de_hl),
    .doah(doah), .doal(doal), .dobh(dobh), .dobl(dobl), .doch(doch), .docl(docl),
    .bank_sel(bank_sel), .swap_flags(swap_flags)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n, input string f, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h want %h", n, f, act, exp);
    end
  endtask

  // Monitor: compare mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      cmp(e_mon.name, "a",    {doah, doal}, e_mon.ea);
      cmp(e_mon.name, "b",    {dobh, dobl}, e_mon.eb);
      cmp(e_mon.name, "c",    {doch, docl}, e_mon.ec);
      cmp(e_mon.name, "bank", {15'd0, bank_sel}, {15'd0, e_mon.ebank});
      cmp(e_mon.name, "swap", {14'd0, swap_flags}, {14'd0, e_mon.esw});
    end
  end

  task automatic drv(input logic c, input logic wh, input logic wl, input logic [2:0] a,
                     input logic [15:0] d, input logic x, input logic s);
    cen = c; weh = wh; wel = wl; addr_a = a;
    dih = d[15:8]; dil = d[7:0]; exx = x; ex_de_hl = s;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    cen = 1'b1; weh = 1'b0; wel = 1'b0; exx = 1'b0; ex_de_hl = 1'b0;
    addr_a = a; addr_b = b; addr_c = c;
  endtask

  task automatic chk(input string n, input logic [15:0] ea, input logic [15:0] eb,
                     input logic [15:0] ec, input logic bk, input logic [1:0] sw);
    exp_t e;
    e.name = n; e.ea = ea; e.eb = eb; e.ec = ec; e.ebank = bk; e.esw = sw;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
    weh = 1'b0; wel = 1'b0; exx = 1'b0; ex_de_hl = 1'b0;
  endtask

  task automatic pulse_exx();  drv(1, 0, 0, 3'd0, 16'h0, 1, 0); step(); endtask
  task automatic pulse_exdh(); drv(1, 0, 0, 3'd0, 16'h0, 0, 1); step(); endtask

  initial begin
    reset_n = 1'b0; addr_b = 3'd0; addr_c = 3'd0;
    drv(1, 1, 1, 3'd0, 16'h5A5A, 1, 1);   // reset must win over write/swaps
    step(); step();
    reset_n = 1'b1;

    rd(0, 1, 2); chk("rst012", 0, 0, 0, 0, 2'b00); step();
    rd(3, 4, 5); chk("rst345", 0, 0, 0, 0, 2'b00); step();
    rd(6, 7, 0); chk("rst670", 0, 0, 0, 0, 2'b00); step();

    // Writes to unused addresses are dropped
    drv(1, 1, 1, 3'd5, 16'hFFFF, 0, 0); step();
    drv(1, 1, 1, 3'd7, 16'hFFFF, 0, 0); step();
    rd(5, 7, 6); chk("unused", 0, 0, 0, 0, 2'b00); step();

    // EXX bank swap of BC
    drv(1, 1, 1, 3'd0, 16'h1234, 0, 0); step();
    pulse_exx();
    drv(1, 1, 1, 3'd0, 16'hABCD, 0, 0); step();
    pulse_exx();
    rd(0, 0, 0); chk("bc_b0", 16'h1234, 16'h1234, 16'h1234, 0, 2'b00); step();
    pulse_exx();
    rd(0, 0, 0); chk("bc_b1", 16'hABCD, 16'hABCD, 16'hABCD, 1, 2'b00); step();
    pulse_exx();

    // EX DE,HL
    drv(1, 1, 1, 3'd1, 16'h1111, 0, 0); step();
    drv(1, 1, 1, 3'd2, 16'h2222, 0, 0); step();
    rd(1, 2, 0); chk("pre_swap", 16'h1111, 16'h2222, 16'h1234, 0, 2'b00); step();
    pulse_exdh();
    rd(1, 2, 0); chk("swapped", 16'h2222, 16'h1111, 16'h1234, 0, 2'b01); step();
    pulse_exx();
    rd(1, 2, 0); chk("b1_unsw", 16'h0000, 16'h0000, 16'hABCD, 1, 2'b01); step();
    pulse_exx();
    rd(1, 2, 0); chk("b0_sw", 16'h2222, 16'h1111, 16'h1234, 0, 2'b01); step();

    // Write + exx + ex_de_hl in one cycle from a clean state
    reset_n = 1'b0; step(); reset_n = 1'b1;
    rd(1, 2, 0); chk("rst2", 0, 0, 0, 0, 2'b00); step();
    drv(1, 1, 1, 3'd1, 16'h5555, 1, 1); step();
    rd(1, 2, 0); chk("same_b1", 0, 0, 0, 1, 2'b01); step();
    pulse_exx();
    rd(1, 2, 0); chk("same_b0", 16'h0000, 16'h5555, 16'h0000, 0, 2'b01); step();

    // IX is unaffected by swaps; same-cycle read shows the old value
    drv(1, 1, 1, 3'd3, 16'hBEEF, 0, 0); addr_b = 3'd3; addr_c = 3'd3;
    chk("ix_nobyp", 0, 0, 0, 0, 2'b01); step();
    rd(3, 3, 3); chk("ix", 16'hBEEF, 16'hBEEF, 16'hBEEF, 0, 2'b01); step();
    pulse_exx();
    rd(3, 3, 3); chk("ix_x", 16'hBEEF, 16'hBEEF, 16'hBEEF, 1, 2'b01); step();
    pulse_exdh();
    rd(3, 3, 3); chk("ix_xs", 16'hBEEF, 16'hBEEF, 16'hBEEF, 1, 2'b11); step();
    pulse_exx();
    rd(3, 3, 3); chk("ix_xsx", 16'hBEEF, 16'hBEEF, 16'hBEEF, 0, 2'b11); step();
    pulse_exdh();
    rd(3, 3, 3); chk("ix_xsxs", 16'hBEEF, 16'hBEEF, 16'hBEEF, 0, 2'b10); step();
    drv(1, 1, 0, 3'd3, 16'h0011, 0, 0); step();
    rd(3, 3, 3); chk("weh_only", 16'h00EF, 16'h00EF, 16'h00EF, 0, 2'b10); step();

    // cen low: nothing happens
    drv(0, 1, 1, 3'd0, 16'h9999, 1, 1); step();
    drv(0, 1, 1, 3'd3, 16'h9999, 1, 1); step();
    rd(0, 3, 4); chk("cen0", 16'h0000, 16'h00EF, 16'h0000, 0, 2'b10); step();

    // Back-to-back exx
    pulse_exx();
    drv(1, 0, 0, 3'd0, 16'h0, 1, 0);
    chk("exx_mid", 16'h0000, 16'h00EF, 16'h0000, 1, 2'b10); step();
    rd(0, 3, 4); chk("exx2", 16'h0000, 16'h00EF, 16'h0000, 0, 2'b10); step();

    // Reset coincident with a write
    reset_n = 1'b0; drv(1, 1, 1, 3'd3, 16'h7777, 1, 1); step();
    reset_n = 1'b1;
    rd(3, 1, 2); chk("rst_wr", 0, 0, 0, 0, 2'b00); step();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
